// File: rtl/tanimoto_pkg.sv
// Shared widths, mode encodings, lane slicing macro and compare helper
// for the multi-lane Tanimoto threshold comparator.
`ifndef TANIMOTO_PKG_SV
`define TANIMOTO_PKG_SV

`define TANIMOTO_LANE(k) (k)*tanimoto_pkg::CNT_WIDTH +: tanimoto_pkg::CNT_WIDTH

package tanimoto_pkg;
    localparam int VECTOR_WIDTH = 920;
    localparam int CNT_WIDTH    = $clog2(VECTOR_WIDTH + 1);
    localparam int SUM_WIDTH    = CNT_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(VECTOR_WIDTH);

    localparam logic MODE_GE = 1'b0;
    localparam logic MODE_LT = 1'b1;

    function automatic logic tanimoto_hit(input logic [SUM_WIDTH-1:0] sum,
                                          input logic [SUM_WIDTH-1:0] thr,
                                          input logic                 mode);
        logic hit;
        case (mode)
            MODE_GE: hit = (sum >= thr);
            MODE_LT: hit = (sum < thr);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction
endpackage

`endif

// File: rtl/block_ram_rd_1st.sv
// Single-port read-first block RAM; the read port only updates on i_En so
// the output holds across pipeline stalls.
module block_ram_rd_1st #(
    parameter int DEPTH = 921,
    parameter int WIDTH = 11,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_En,
    input  logic             i_WrEn,
    input  logic [AW-1:0]    i_Addr,
    input  logic [WIDTH-1:0] i_Din,
    output logic [WIDTH-1:0] o_Dout
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Memory array write and enabled read-first output register
    always_ff @(posedge clk) begin
        if (i_WrEn) begin
            r_mem[i_Addr] <= i_Din;
        end
        if (i_En) begin
            o_Dout <= r_mem[i_Addr];
        end
    end
endmodule

// File: rtl/comparator_lane.sv
// One comparator lane: S1 sum/range/threshold read, S2 registered hit flag.
module comparator_lane
    import tanimoto_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_Adv,
    input  logic                 i_S2Load,
    input  logic [CNT_WIDTH-1:0] i_CntA,
    input  logic [CNT_WIDTH-1:0] i_CntB,
    input  logic [CNT_WIDTH-1:0] i_CntC,
    input  logic                 i_Mode,
    input  logic [CNT_WIDTH-1:0] i_Cfg_Addr,
    input  logic [SUM_WIDTH-1:0] i_Cfg_Din,
    input  logic                 i_Cfg_WrEn,
    output logic                 o_Hit
);
    logic                 w_in_range;
    logic [CNT_WIDTH-1:0] w_ram_addr;
    logic [SUM_WIDTH-1:0] w_thr;
    logic [SUM_WIDTH-1:0] r_sum;
    logic                 r_in_range;
    logic                 r_hit;

    assign w_in_range = (i_CntC <= CNT_MAX);

    // Threshold RAM address: config port wins, out-of-range lookups parked at 0
    always_comb begin
        w_ram_addr = {CNT_WIDTH{1'b0}};
        if (i_Cfg_WrEn) begin
            w_ram_addr = i_Cfg_Addr;
        end else if (w_in_range) begin
            w_ram_addr = i_CntC;
        end else begin
            w_ram_addr = {CNT_WIDTH{1'b0}};
        end
    end

    block_ram_rd_1st #(
        .DEPTH (VECTOR_WIDTH + 1),
        .WIDTH (SUM_WIDTH)
    ) u_thr_ram (
        .clk    (clk),
        .i_En   (i_Adv),
        .i_WrEn (i_Cfg_WrEn),
        .i_Addr (w_ram_addr),
        .i_Din  (i_Cfg_Din),
        .o_Dout (w_thr)
    );

    // S1 sum/range registers and S2 hit flag; S2 only loads real beats
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum      <= {SUM_WIDTH{1'b0}};
            r_in_range <= 1'b0;
            r_hit      <= 1'b0;
        end else begin
            if (i_Adv) begin
                r_sum      <= {1'b0, i_CntA} + {1'b0, i_CntB};
                r_in_range <= w_in_range;
            end
            if (i_S2Load) begin
                r_hit <= r_in_range & tanimoto_hit(r_sum, w_thr, i_Mode);
            end
        end
    end

    assign o_Hit = r_hit;
endmodule

// File: rtl/comparator_multilane.sv
// N-lane pipelined Tanimoto threshold comparator with valid/ready handshake.
// Optional feature macro: HIT_COUNT_EN adds per-lane saturating hit counters.
module comparator_multilane
    import tanimoto_pkg::*;
#(
    parameter int N_LANES = 4
`ifdef HIT_COUNT_EN
    , parameter int HIT_WIDTH = 32
`endif
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_LANES*CNT_WIDTH-1:0] i_CntA,
    input  logic [N_LANES*CNT_WIDTH-1:0] i_CntB,
    input  logic [N_LANES*CNT_WIDTH-1:0] i_CntC,
    input  logic                         i_Valid,
    output logic                         o_Ready,
    input  logic                         i_Mode,
    input  logic [CNT_WIDTH-1:0]         i_Cfg_Addr,
    input  logic [SUM_WIDTH-1:0]         i_Cfg_Din,
    input  logic                         i_Cfg_WrEn,
    output logic                         o_Busy,
    output logic [N_LANES-1:0]           o_Dout,
    output logic                         o_Valid,
`ifdef HIT_COUNT_EN
    input  logic                         i_HitClr,
    output logic [N_LANES*HIT_WIDTH-1:0] o_HitCnt,
`endif
    input  logic                         i_Ready
);
    logic               w_adv;
    logic               w_accept;
    logic               w_s2_load;
    logic               r_valid_s1;
    logic               r_valid_s2;
    logic               r_mode_s1;
    logic [N_LANES-1:0] w_hit;

    assign w_adv     = ~r_valid_s2 | i_Ready;
    assign o_Ready   = w_adv & ~i_Cfg_WrEn;
    assign w_accept  = i_Valid & o_Ready;
    assign w_s2_load = w_adv & r_valid_s1;

    // Valid pipeline and per-beat mode; everything freezes while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid_s1 <= 1'b0;
            r_valid_s2 <= 1'b0;
            r_mode_s1  <= MODE_GE;
        end else if (w_adv) begin
            r_valid_s1 <= w_accept;
            r_valid_s2 <= r_valid_s1;
            r_mode_s1  <= i_Mode;
        end
    end

    assign o_Valid = r_valid_s2;
    assign o_Busy  = r_valid_s1 | r_valid_s2;
    assign o_Dout  = w_hit;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        comparator_lane u_lane (
            .clk        (clk),
            .rstn       (rstn),
            .i_Adv      (w_adv),
            .i_S2Load   (w_s2_load),
            .i_CntA     (i_CntA[`TANIMOTO_LANE(k)]),
            .i_CntB     (i_CntB[`TANIMOTO_LANE(k)]),
            .i_CntC     (i_CntC[`TANIMOTO_LANE(k)]),
            .i_Mode     (r_mode_s1),
            .i_Cfg_Addr (i_Cfg_Addr),
            .i_Cfg_Din  (i_Cfg_Din),
            .i_Cfg_WrEn (i_Cfg_WrEn),
            .o_Hit      (w_hit[k])
        );
    end

`ifdef HIT_COUNT_EN
    logic w_out_fire;
    assign w_out_fire = o_Valid & i_Ready;

    for (genvar k = 0; k < N_LANES; k++) begin : g_hit_cnt
        logic [HIT_WIDTH-1:0] r_cnt;

        // Saturating hit counter; clear takes priority over increment
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_cnt <= {HIT_WIDTH{1'b0}};
            end else if (i_HitClr) begin
                r_cnt <= {HIT_WIDTH{1'b0}};
            end else if (w_out_fire & o_Dout[k] & ~(&r_cnt)) begin
                r_cnt <= r_cnt + HIT_WIDTH'(1);
            end
        end

        assign o_HitCnt[k*HIT_WIDTH +: HIT_WIDTH] = r_cnt;
    end
`endif
endmodule

// File: tb/tb_comparator_multilane.sv
// Self-checking bench for comparator_multilane: random traffic against a
// threshold-table reference model plus directed corner beats.
module tb_comparator_multilane;
    import tanimoto_pkg::*;

    localparam int NL = 4;
    localparam int CW = CNT_WIDTH;
`ifdef HIT_COUNT_EN
    localparam int HW = 4;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NL*CW-1:0] cnt_a = '0;
    logic [NL*CW-1:0] cnt_b = '0;
    logic [NL*CW-1:0] cnt_c = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            mode = 1'b0;
    logic [CW-1:0]   cfg_addr = '0;
    logic [CW:0]     cfg_din = '0;
    logic            cfg_we = 1'b0;
    logic            busy;
    logic [NL-1:0]   dout;
    logic            out_valid;
    logic            ds_ready = 1'b1;
`ifdef HIT_COUNT_EN
    logic            hit_clr = 1'b0;
    logic [NL*HW-1:0] hit_cnt;
`endif

    comparator_multilane #(
        .N_LANES (NL)
`ifdef HIT_COUNT_EN
        , .HIT_WIDTH (HW)
`endif
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_CntA     (cnt_a),
        .i_CntB     (cnt_b),
        .i_CntC     (cnt_c),
        .i_Valid    (in_valid),
        .o_Ready    (in_ready),
        .i_Mode     (mode),
        .i_Cfg_Addr (cfg_addr),
        .i_Cfg_Din  (cfg_din),
        .i_Cfg_WrEn (cfg_we),
        .o_Busy     (busy),
        .o_Dout     (dout),
        .o_Valid    (out_valid),
`ifdef HIT_COUNT_EN
        .i_HitClr   (hit_clr),
        .o_HitCnt   (hit_cnt),
`endif
        .i_Ready    (ds_ready)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            thr_m [0:VECTOR_WIDTH];
    logic [NL-1:0] exp_q [$];
    logic          prev_stall = 1'b0;
    logic [NL-1:0] prev_dout = '0;
    int            n_out = 0;
    int            n_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit(input int a, input int b, input int c, input logic m);
        int sum;
        sum = a + b;
        if (c > VECTOR_WIDTH) return 1'b0;
        if (m) return (sum < thr_m[c]);
        return (sum >= thr_m[c]);
    endfunction

    function automatic logic [NL-1:0] model_beat();
        logic [NL-1:0] r;
        for (int k = 0; k < NL; k++) begin
            r[k] = model_hit(int'(cnt_a[k*CW +: CW]), int'(cnt_b[k*CW +: CW]),
                             int'(cnt_c[k*CW +: CW]), mode);
        end
        return r;
    endfunction

    task automatic set_lane(input int k, input int a, input int b, input int c);
        cnt_a[k*CW +: CW] = CW'(a);
        cnt_b[k*CW +: CW] = CW'(b);
        cnt_c[k*CW +: CW] = CW'(c);
    endtask

    task automatic randomize_lanes();
        for (int k = 0; k < NL; k++) begin
            set_lane(k, int'($urandom_range(0, 920)), int'($urandom_range(0, 920)),
                     int'($urandom_range(0, 1023)));
        end
    endtask

    // One clock: checks at negedge+1, model updates with the edge.
    task automatic tick();
        #1;
        if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_dout", 64'(dout), 64'(prev_dout));
        end
        if (out_valid && !ds_ready) chk("ready_full", 64'(in_ready), 64'd0);
        if (cfg_we) chk("cfg_ready", 64'(in_ready), 64'd0);
        if (out_valid && ds_ready) begin
            chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk("dout", 64'(dout), 64'(exp_q.pop_front()));
            n_out++;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model_beat());
            n_acc++;
        end
        prev_stall = out_valid && !ds_ready;
        prev_dout  = dout;
        @(posedge clk);
        if (cfg_we) thr_m[cfg_addr] = int'(cfg_din);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        ds_ready = 1'b1;
        for (int i = 0; i < 10 && (busy || exp_q.size() > 0); i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_idle", 64'(busy), 64'd0);
    endtask

    task automatic cfg_write(input int addr, input int din);
        cfg_we   = 1'b1;
        cfg_addr = CW'(addr);
        cfg_din  = (CW+1)'(din);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic directed(input string tag, input int a, input int b, input int c,
                            input logic m, input logic exp_hit);
        randomize_lanes();
        set_lane(0, a, b, c);
        mode     = m;
        in_valid = 1'b1;
        ds_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        tick();
        chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
        chk(tag, 64'(dout[0]), 64'(exp_hit));
        drain();
    endtask

    initial begin
        int n0;
        int a0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        for (int i = 0; i <= VECTOR_WIDTH; i++) cfg_write(i, int'($urandom_range(0, 1900)));

        cfg_write(300, 600);
        directed("t1_ge_hit", 310, 290, 300, MODE_GE, 1'b1);
        directed("t1_ge_miss", 310, 289, 300, MODE_GE, 1'b0);
        directed("t2_lt_miss", 310, 290, 300, MODE_LT, 1'b0);
        directed("t2_lt_hit", 310, 289, 300, MODE_LT, 1'b1);
        directed("t2_oor_ge", 310, 290, 921, MODE_GE, 1'b0);
        directed("t2_oor_lt", 310, 290, 921, MODE_LT, 1'b0);
        cfg_write(0, 1840);
        directed("t3_width", 920, 920, 0, MODE_GE, 1'b1);

        n0 = n_out;
        a0 = n_acc;
        for (int k = 0; k < 20 && (n_out - n0) < 4; k++) begin
            in_valid = (n_acc - a0) < 4;
            randomize_lanes();
            mode     = 1'($urandom_range(0, 1));
            ds_ready = !(k >= 3 && k < 6);
            tick();
        end
        drain();
        chk("t4_beats_out", 64'(n_out - n0), 64'd4);

        n0 = n_out;
        a0 = n_acc;
        for (int k = 0; k < 400; k++) begin
            in_valid = $urandom_range(0, 99) < 70;
            ds_ready = $urandom_range(0, 99) < 70;
            mode     = 1'($urandom_range(0, 1));
            randomize_lanes();
            tick();
        end
        drain();
        chk("rand_conserved", 64'(n_out - n0), 64'(n_acc - a0));

        randomize_lanes();
        set_lane(0, 310, 290, 300);
        mode     = MODE_GE;
        in_valid = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = CW'(300);
        cfg_din  = (CW+1)'(601);
        a0 = n_acc;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        chk("t5_cfg_no_accept", 64'(n_acc - a0), 64'd0);
        directed("t5_new_thr", 310, 290, 300, MODE_GE, 1'b0);

        in_valid = 1'b1;
        randomize_lanes();
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_dout", 64'(dout), 64'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        directed("t5_thr_kept", 920, 920, 0, MODE_GE, 1'b1);

`ifdef HIT_COUNT_EN
        hit_clr = 1'b1;
        tick();
        hit_clr = 1'b0;
        chk("t6_clr", 64'(hit_cnt[2*HW +: HW]), 64'd0);
        for (int k = 0; k < NL; k++) set_lane(k, 0, 0, 921);
        set_lane(2, 920, 920, 0);
        mode = MODE_GE;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            tick();
        end
        drain();
        chk("t6_count10", 64'(hit_cnt[2*HW +: HW]), 64'd10);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        hit_clr = 1'b1;
        tick();
        hit_clr = 1'b0;
        chk("t6_clr_prio", 64'(hit_cnt[2*HW +: HW]), 64'd0);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            tick();
        end
        drain();
        chk("t6_saturate", 64'(hit_cnt[2*HW +: HW]), 64'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
